// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding and default frame geometry.
// The TX serializer imports the same defaults so both ends agree on the frame shape.
package uart_pkg;

    localparam int UART_DATA_WIDTH_DEF = 8;
    localparam int UART_OVERSAMPLE_DEF = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to 1
// so an idle-high line produces no spurious low after reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive path: synchronize rx_in, find the start bit, sample mid-bit, rebuild the byte LSB first.
// Optional parity checking is built in when the macro UART_RX_PARITY_EN is defined.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH_DEF,
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  os_tick,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  framing_err,
    output logic                  busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    logic rx_s;

    rx_state_t             state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;
    logic                  par_bad;
`ifdef UART_RX_PARITY_EN
    logic                  par_flag_q, par_flag_d;
    logic                  perr_q, perr_d;
`endif

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    assign par_bad = par_flag_q;
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_flag_q <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_flag_q <= par_flag_d;
            perr_q     <= perr_d;
`endif
        end
    end

    // Counters only move on os_tick; without a tick everything holds.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_flag_d = par_flag_q;
        perr_d     = 1'b0;
`endif
        if (os_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    // Half a bit in: a still-low line is a real start bit and fixes mid-bit alignment.
                    if (tick_q == TICK_MID) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == TICK_LAST) begin
                        shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
                        tick_d  = '0;
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
                            bit_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_q == TICK_LAST) begin
                        if (rx_s != ((^shift_q) ^ PARITY_ODD)) begin
                            par_flag_d = 1'b1;
                        end
                        tick_d  = '0;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        state_d = IDLE;
                        if (!rx_s) begin
                            ferr_d = 1'b1;
                        end else if (!par_bad) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        perr_d     = par_flag_q;
                        par_flag_d = 1'b0;
`endif
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            endcase
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign framing_err = ferr_q;
    assign busy        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err  = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed and randomized frames against a frame-level expectation queue for uart_rx_deserializer.
module tb_uart_rx_deserializer;

  localparam int DW = 8;
  localparam int OS = 8;
  localparam bit PAR_ODD = 1'b0;

  logic clk = 1'b0;
  logic rst;
  logic rx_in;
  logic os_tick;
  logic [DW-1:0] data_out;
  logic data_valid;
  logic framing_err;
  logic busy;
  logic perr_w;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
  assign perr_w = parity_err;
`else
  assign perr_w = 1'b0;
`endif

  int compared = 0;
  int mismatched = 0;

  // Entry: {parity_err, framing_err, data_out value expected at the pulse}
  logic [DW+1:0] exp_q[$];
  logic [DW-1:0] last_good;
  int tick_p = 1;
  int tick_div = 0;
  bit break_mode = 1'b0;
  int brk_ferr = 0;
  int brk_dv = 0;

  uart_rx_deserializer dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .os_tick     (os_tick),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .framing_err (framing_err),
    .busy        (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  // clock/reset block
  always #5 clk = ~clk;

  // os_tick generator: one pulse every tick_p clocks
  always @(negedge clk) begin
    if (tick_div >= tick_p - 1) begin
      os_tick = 1'b1;
      tick_div = 0;
    end else begin
      os_tick = 1'b0;
      tick_div++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // scoreboard: every output pulse must match the head of exp_q
  always @(negedge clk) begin
    logic [DW+1:0] e;
    if (rst === 1'b1 && (data_valid === 1'b1 || framing_err === 1'b1 || perr_w === 1'b1)) begin
      if (break_mode) begin
        if (framing_err) brk_ferr++;
        if (data_valid) brk_dv++;
      end else if (exp_q.size() == 0) begin
        check("pulse_without_expectation", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("framing_err_pulse", 32'(framing_err), 32'(e[DW]));
        check("data_valid_pulse", 32'(data_valid), 32'(!e[DW] && !e[DW+1]));
        check("data_out_at_pulse", 32'(data_out), 32'(e[DW-1:0]));
`ifdef UART_RX_PARITY_EN
        check("parity_err_pulse", 32'(perr_w), 32'(e[DW+1]));
`endif
      end
    end
  end

  // driver tasks
  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (OS * tick_p) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop, input logic par_flip);
    logic ok;
    ok = stop && !par_flip;
`ifndef UART_RX_PARITY_EN
    ok = stop;
`endif
    exp_q.push_back({par_flip, !stop, ok ? d : last_good});
    if (ok) last_good = d;
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ PAR_ODD ^ par_flip);
`endif
    drive_bit(stop);
  endtask

  initial begin
    logic [DW-1:0] v;
    logic [DW-1:0] rd;
    logic rs;
    int gap;

    rst = 1'b0;
    rx_in = 1'b1;
    os_tick = 1'b0;
    last_good = '0;
    repeat (3) @(negedge clk);
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_data_valid", 32'(data_valid), 32'h0);
    check("reset_framing_err", 32'(framing_err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // good frame 0xA5
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("a5_queue_drained", 32'(exp_q.size()), 32'd0);
    check("a5_data_out", 32'(data_out), 32'hA5);
    check("a5_busy_after", 32'(busy), 32'h0);

    // start glitch: two clocks low, then high
    repeat (16) @(negedge clk);
    rx_in = 1'b0;
    repeat (2) @(negedge clk);
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy_high", 32'(busy), 32'h1);
    repeat (4) @(negedge clk);
    check("glitch_busy_low", 32'(busy), 32'h0);
    check("glitch_data_out", 32'(data_out), 32'hA5);

    // framing error: 0x3C with stop low
    repeat (16) @(negedge clk);
    send_frame(8'h3C, 1'b0, 1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("ferr_queue_drained", 32'(exp_q.size()), 32'd0);
    check("ferr_data_out_kept", 32'(data_out), 32'hA5);

    // back-to-back 0x00 then 0xFF
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    drive_bit(1'b1);
    check("b2b_queue_drained", 32'(exp_q.size()), 32'd0);
    check("b2b_data_out", 32'(data_out), 32'hFF);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    drive_bit(1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    drive_bit(1'b1);
    check("parity_queue_drained", 32'(exp_q.size()), 32'd0);
    check("parity_data_out", 32'(data_out), 32'h07);
`endif

    // break: line held low for 30 bit times
    break_mode = 1'b1;
    brk_ferr = 0;
    brk_dv = 0;
    rx_in = 1'b0;
    repeat (30 * OS) @(negedge clk);
    check("break_no_data_valid", 32'(brk_dv), 32'd0);
    check("break_ferr_repeats", 32'(brk_ferr >= 2 && brk_ferr <= 4), 32'd1);
    rx_in = 1'b1;
    repeat (14 * OS) @(negedge clk);
    break_mode = 1'b0;

    // reset after the 4th data bit of 0x5A
    v = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(v[i]);
    rst = 1'b0;
    last_good = '0;
    repeat (2) @(negedge clk);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_data_out", 32'(data_out), 32'h0);
    check("midrst_data_valid", 32'(data_valid), 32'h0);
    check("midrst_framing_err", 32'(framing_err), 32'h0);
    rx_in = 1'b1;
    rst = 1'b1;
    repeat (2 * OS) @(negedge clk);
    send_frame(8'h81, 1'b1, 1'b0);
    drive_bit(1'b1);
    check("post_rst_queue_drained", 32'(exp_q.size()), 32'd0);
    check("post_rst_data_out", 32'(data_out), 32'h81);

    // randomized frames with varying tick spacing and idle gaps
    for (int n = 0; n < 24; n++) begin
      tick_p = $urandom_range(1, 3);
      rd = DW'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      send_frame(rd, rs, 1'b0);
      gap = rs ? $urandom_range(0, 2) : $urandom_range(1, 2);
      for (int g = 0; g < gap; g++) drive_bit(1'b1);
    end
    drive_bit(1'b1);
    repeat (4 * OS) @(negedge clk);
    check("random_queue_drained", 32'(exp_q.size()), 32'd0);
    check("random_final_data_out", 32'(data_out), 32'(last_good));
    check("random_final_busy", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
